// File: rtl/fpu_div_pkg.sv
// Shared types and sizes for the FPU significand divide path.
// Contents: div_state_t FSM encoding, divider width, latency and counter width.
package fpu_div_pkg;

  localparam int unsigned DIV_WID  = 88;
  localparam int unsigned DIV_LAT  = DIV_WID;
  localparam int unsigned DIV_CNTW = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div88_step.sv
// One restoring radix-2 division step, purely combinational.
// Ports:
//   prem     - current partial remainder (always < divisor)
//   dvd_msb  - next dividend bit shifted into the remainder
//   divisor  - divisor
//   prem_nxt - partial remainder after this step
//   qbit     - quotient bit produced by this step
module div88_step
  import fpu_div_pkg::*;
#(
  parameter int unsigned WID = DIV_WID
) (
  input  logic [WID-1:0] prem,
  input  logic           dvd_msb,
  input  logic [WID-1:0] divisor,
  output logic [WID-1:0] prem_nxt,
  output logic           qbit
);

  logic [WID:0] trial;

  // One bit wider than the operands so the borrow lands in the MSB.
  assign trial    = {prem, dvd_msb} - {1'b0, divisor};
  assign qbit     = ~trial[WID];
  assign prem_nxt = qbit ? trial[WID-1:0] : {prem[WID-2:0], dvd_msb};

endmodule

// File: rtl/div88_seq.sv
// Iterative radix-2 unsigned divider, one quotient bit per enabled clock.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   ce         - global clock enable; everything holds while low
//   ld         - start request, accepted in IDLE or DONE
//   a, b       - dividend and divisor, captured when ld is accepted
//   q, r       - registered quotient and remainder
//   busy       - division in progress
//   done       - q, r, dbz valid (level, held until the next accepted ld)
//   dbz        - divide-by-zero flag
module div88_seq
  import fpu_div_pkg::*;
#(
  parameter int unsigned WID  = DIV_WID,
  parameter int unsigned CNTW = DIV_CNTW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           ld,
  input  logic [WID-1:0] a,
  input  logic [WID-1:0] b,
  output logic [WID-1:0] q,
  output logic [WID-1:0] r,
  output logic           busy,
  output logic           done,
  output logic           dbz
);

  div_state_t      state, state_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic [WID-1:0]  dvd, dvd_nxt;
  logic [WID-1:0]  dvs, dvs_nxt;
  logic [WID-1:0]  prem, prem_nxt;
  logic [WID-1:0]  q_nxt, r_nxt;
  logic            busy_nxt, done_nxt, dbz_nxt;

  logic [WID-1:0]  step_prem;
  logic            step_qbit;
  logic [WID-1:0]  dvd_shift;
  logic            b_zero;

  div88_step #(.WID(WID)) u_step (
    .prem     (prem),
    .dvd_msb  (dvd[WID-1]),
    .divisor  (dvs),
    .prem_nxt (step_prem),
    .qbit     (step_qbit)
  );

  // The dividend register doubles as the quotient register.
  assign dvd_shift = {dvd[WID-2:0], step_qbit};
  assign b_zero    = (b == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (ld) state_nxt = b_zero ? DONE : DIV;
      DIV:        if (cnt == '0) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    cnt_nxt  = cnt;
    dvd_nxt  = dvd;
    dvs_nxt  = dvs;
    prem_nxt = prem;
    q_nxt    = q;
    r_nxt    = r;
    busy_nxt = busy;
    done_nxt = done;
    dbz_nxt  = dbz;
    case (state)
      IDLE, DONE: begin
        if (ld) begin
          if (b_zero) begin
            q_nxt    = '1;
            r_nxt    = a;
            dbz_nxt  = 1'b1;
            done_nxt = 1'b1;
            busy_nxt = 1'b0;
          end else begin
            dvd_nxt  = a;
            dvs_nxt  = b;
            prem_nxt = '0;
            cnt_nxt  = CNTW'(WID - 1);
            busy_nxt = 1'b1;
            done_nxt = 1'b0;
            dbz_nxt  = 1'b0;
          end
        end
      end
      DIV: begin
        dvd_nxt  = dvd_shift;
        prem_nxt = step_prem;
        cnt_nxt  = cnt - CNTW'(1);
        if (cnt == '0) begin
          q_nxt    = dvd_shift;
          r_nxt    = step_prem;
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dvd  <= '0;
      dvs  <= '0;
      prem <= '0;
      q    <= '0;
      r    <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      dbz  <= 1'b0;
    end else if (ce) begin
      cnt  <= cnt_nxt;
      dvd  <= dvd_nxt;
      dvs  <= dvs_nxt;
      prem <= prem_nxt;
      q    <= q_nxt;
      r    <= r_nxt;
      busy <= busy_nxt;
      done <= done_nxt;
      dbz  <= dbz_nxt;
    end
  end

endmodule

// File: tb/tb_div88_seq.sv
// Scoreboard bench for div88_seq: the driver pushes hand-computed results,
// a monitor pops and compares each time the divider presents a new result.
module tb_div88_seq;
  import fpu_div_pkg::*;

  localparam int unsigned W = DIV_WID;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ce = 1'b1;
  logic         ld = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] q, r;
  logic         busy, done, dbz;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  div88_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .ld    (ld),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  function automatic void chk(input string name, input logic [W-1:0] act,
                              input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endfunction

  // Monitor: a result is presented when done rises, or when an accepted ld
  // from a non-busy state leaves done high (divide-by-zero issued from DONE).
  logic prev_done = 1'b0;
  logic prev_busy = 1'b0;
  always @(posedge clk) begin
    logic ld_s, ce_s;
    res_t e;
    ld_s = ld;
    ce_s = ce;
    #1;
    if (rst_n && done && (!prev_done || (ld_s && ce_s && !prev_busy))) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got q=0x%0h r=0x%0h with no pending expectation", q, r);
      end else begin
        e = exp_q.pop_front();
        chk("result_q", q, e.q);
        chk("result_r", r, e.r);
        chk("result_dbz", W'(dbz), W'(e.dbz));
      end
    end
    prev_done = done;
    prev_busy = busy;
  end

  // Issue one operation and measure latency and busy cycles from the ld edge.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ed, input int elat, input int ebusy,
                        input int stall_at, input int stall_len,
                        input int pulse_at);
    int           n;
    int           nbusy;
    int           frozen_bad;
    logic [W-1:0] sq, sr;
    logic         sbusy, sdone;
    res_t         e;
    @(negedge clk);
    a  = av;
    b  = bv;
    ld = 1'b1;
    e  = '{q: eq, r: er, dbz: ed};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    ld = 1'b0;
    n = 0;
    nbusy = int'(busy);
    frozen_bad = 0;
    sq = q; sr = r; sbusy = busy; sdone = done;
    while (!done && n < 300) begin
      if (n == pulse_at) begin
        ld = 1'b1;
        a  = W'(9);
        b  = W'(9);
      end else begin
        ld = 1'b0;
      end
      if (n == stall_at) begin
        ce = 1'b0;
        sq = q; sr = r; sbusy = busy; sdone = done;
      end
      if (n == stall_at + stall_len) ce = 1'b1;
      @(posedge clk);
      #1;
      n++;
      nbusy += int'(busy);
      if (stall_at >= 0 && n > stall_at && n <= stall_at + stall_len) begin
        if (q !== sq || r !== sr || busy !== sbusy || done !== sdone) frozen_bad++;
      end
    end
    ld = 1'b0;
    ce = 1'b1;
    chk("latency", W'(n), W'(elat));
    chk("busy_cycles", W'(nbusy), W'(ebusy));
    if (stall_at >= 0) chk("stall_frozen", W'(frozen_bad), '0);
  endtask

  initial begin
    logic [W-1:0] ones, p44, p44m1;
    ones  = '1;
    p44   = W'(1) << 44;
    p44m1 = p44 - W'(1);

    // Reset state.
    #12;
    chk("reset_q", q, '0);
    chk("reset_r", r, '0);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_dbz", W'(dbz), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic divide and full-scale operands.
    run_op(W'(100), W'(7), W'(14), W'(2), 1'b0, DIV_LAT, DIV_LAT, -1, 0, -1);
    run_op(ones, W'(1), ones, '0, 1'b0, DIV_LAT, DIV_LAT, -1, 0, -1);
    run_op(ones, p44, p44m1, p44m1, 1'b0, DIV_LAT, DIV_LAT, -1, 0, -1);

    // Divide by zero: result on the accepting edge, busy never set.
    run_op(W'(16'h1234), '0, ones, W'(16'h1234), 1'b1, 0, 0, -1, 0, -1);
    run_op(W'(5), W'(10), '0, W'(5), 1'b0, DIV_LAT, DIV_LAT, -1, 0, -1);
    run_op('0, W'(3), '0, '0, 1'b0, DIV_LAT, DIV_LAT, -1, 0, -1);

    // Clock-enable stall of 10 cycles mid-division.
    run_op(W'(1000), W'(3), W'(333), W'(1), 1'b0, DIV_LAT + 10, DIV_LAT + 10, 30, 10, -1);

    // ld during DIV is ignored; ld on the done cycle issues back-to-back.
    run_op(W'(200), W'(7), W'(28), W'(4), 1'b0, DIV_LAT, DIV_LAT, -1, 0, 20);
    run_op(W'(81), W'(9), W'(9), '0, 1'b0, DIV_LAT, DIV_LAT, -1, 0, -1);

    // Reset mid-operation aborts it asynchronously.
    @(negedge clk);
    a  = W'(12345);
    b  = W'(6);
    ld = 1'b1;
    @(posedge clk);
    #1;
    ld = 1'b0;
    repeat (40) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", W'(busy), '0);
    chk("abort_done", W'(done), '0);
    chk("abort_q", q, '0);
    chk("abort_r", r, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(W'(50), W'(5), W'(10), '0, 1'b0, DIV_LAT, DIV_LAT, -1, 0, -1);

    @(negedge clk);
    chk("pending_results", W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
